// File: rtl/airi5c_wb_collect_pkg.sv
// Shared widths and encodings for the write-back collector and its helpers.
package airi5c_wb_collect_pkg;

  localparam int XPR_LEN          = 32;
  localparam int WB_SRC_SEL_WIDTH = 2;

  // Result source select codes
  localparam logic [WB_SRC_SEL_WIDTH-1:0] WB_SRC_ALU  = 2'd0;
  localparam logic [WB_SRC_SEL_WIDTH-1:0] WB_SRC_MEM  = 2'd1;
  localparam logic [WB_SRC_SEL_WIDTH-1:0] WB_SRC_CSR  = 2'd2;
  localparam logic [WB_SRC_SEL_WIDTH-1:0] WB_SRC_LINK = 2'd3;

  // Load funct3 codes
  localparam logic [2:0] RV32_FUNCT3_LB  = 3'b000;
  localparam logic [2:0] RV32_FUNCT3_LH  = 3'b001;
  localparam logic [2:0] RV32_FUNCT3_LW  = 3'b010;
  localparam logic [2:0] RV32_FUNCT3_LBU = 3'b100;
  localparam logic [2:0] RV32_FUNCT3_LHU = 3'b101;

endpackage

// File: rtl/airi5c_wb_collect_load_align.sv
// Load data alignment and sign/zero extension; purely combinational so the
// debug module can reuse it on its own memory path.
import airi5c_wb_collect_pkg::*;

module airi5c_load_align (
  input  logic [2:0]         mem_type,
  input  logic [1:0]         addr_lsb,
  input  logic [XPR_LEN-1:0] rdata,
  output logic [XPR_LEN-1:0] data
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Pick the addressed byte and halfword, then extend according to the load type
  always_comb begin
    sel_byte = rdata[7:0];
    case (addr_lsb)
      2'd0: sel_byte = rdata[7:0];
      2'd1: sel_byte = rdata[15:8];
      2'd2: sel_byte = rdata[23:16];
      2'd3: sel_byte = rdata[31:24];
      default: sel_byte = rdata[7:0];
    endcase
    sel_half = addr_lsb[1] ? rdata[31:16] : rdata[15:0];
    case (mem_type)
      RV32_FUNCT3_LB:  data = {{(XPR_LEN-8){sel_byte[7]}}, sel_byte};
      RV32_FUNCT3_LH:  data = {{(XPR_LEN-16){sel_half[15]}}, sel_half};
      RV32_FUNCT3_LBU: data = {{(XPR_LEN-8){1'b0}}, sel_byte};
      RV32_FUNCT3_LHU: data = {{(XPR_LEN-16){1'b0}}, sel_half};
      RV32_FUNCT3_LW:  data = rdata;
      default:         data = rdata;
    endcase
  end

endmodule

// File: rtl/airi5c_wb_collect.sv
// Write-back collector: takes one retiring instruction from EX, picks the
// result source, waits for the load response when needed and drives a single
// registered register-file write port (also the operand bypass source).
import airi5c_wb_collect_pkg::*;

module airi5c_wb_collect (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        ex_valid_i,
  output logic                        ex_ready_o,
  input  logic [WB_SRC_SEL_WIDTH-1:0] wb_src_sel_i,
  input  logic [4:0]                  rd_addr_i,
  input  logic                        rd_wen_i,
  input  logic [XPR_LEN-1:0]          alu_result_i,
  input  logic [XPR_LEN-1:0]          csr_rdata_i,
  input  logic [XPR_LEN-1:0]          pc_i,
  input  logic                        was_compressed_i,
  input  logic [2:0]                  mem_type_i,
  input  logic [1:0]                  mem_addr_lsb_i,
  input  logic                        dmem_rvalid_i,
  input  logic [XPR_LEN-1:0]          dmem_rdata_i,
  input  logic                        dmem_err_i,
  output logic                        rf_wen_o,
  output logic [4:0]                  rf_waddr_o,
  output logic [XPR_LEN-1:0]          rf_wdata_o,
  output logic                        load_err_o
);

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t             state, next_state;
  logic [4:0]         cap_rd_addr;
  logic               cap_rd_wen;
  logic [2:0]         cap_mem_type;
  logic [1:0]         cap_addr_lsb;
  logic [XPR_LEN-1:0] load_data;
  logic [XPR_LEN-1:0] link_addr;
  logic               wb_wen;
  logic [4:0]         wb_addr;
  logic [XPR_LEN-1:0] wb_data;
  logic               wb_err;
  logic               accept;

  assign ex_ready_o = (state == IDLE);
  assign accept     = ex_valid_i & ex_ready_o;
  assign link_addr  = pc_i + (was_compressed_i ? XPR_LEN'(2) : XPR_LEN'(4));

  airi5c_load_align u_load_align (
    .mem_type (cap_mem_type),
    .addr_lsb (cap_addr_lsb),
    .rdata    (dmem_rdata_i),
    .data     (load_data)
  );

  // State register; reset abandons any outstanding load
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= next_state;
  end

  // Capture the destination and load shape of the accepted instruction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cap_rd_addr  <= '0;
      cap_rd_wen   <= 1'b0;
      cap_mem_type <= '0;
      cap_addr_lsb <= '0;
    end else if (accept) begin
      cap_rd_addr  <= rd_addr_i;
      cap_rd_wen   <= rd_wen_i;
      cap_mem_type <= mem_type_i;
      cap_addr_lsb <= mem_addr_lsb_i;
    end
  end

  // Next state and the write/error request for the coming edge
  always_comb begin
    next_state = state;
    wb_wen     = 1'b0;
    wb_addr    = rd_addr_i;
    wb_data    = '0;
    wb_err     = 1'b0;
    case (state)
      IDLE: begin
        if (ex_valid_i) begin
          if (wb_src_sel_i == WB_SRC_MEM) begin
            next_state = WAIT_MEM;
          end else begin
            wb_wen = rd_wen_i & (rd_addr_i != 5'd0);
            case (wb_src_sel_i)
              WB_SRC_ALU:  wb_data = alu_result_i;
              WB_SRC_CSR:  wb_data = csr_rdata_i;
              WB_SRC_LINK: wb_data = link_addr;
              default:     wb_data = '0;
            endcase
          end
        end
      end
      WAIT_MEM: begin
        wb_addr = cap_rd_addr;
        if (dmem_rvalid_i) begin
          next_state = IDLE;
          if (dmem_err_i) begin
            wb_err = 1'b1;
          end else begin
            wb_wen  = cap_rd_wen & (cap_rd_addr != 5'd0);
            wb_data = load_data;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Registered write port; address and data hold while no write is issued
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rf_wen_o   <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      load_err_o <= 1'b0;
    end else begin
      rf_wen_o   <= wb_wen;
      load_err_o <= wb_err;
      if (wb_wen) begin
        rf_waddr_o <= wb_addr;
        rf_wdata_o <= wb_data;
      end
    end
  end

endmodule

// File: tb/tb_airi5c_wb_collect.sv
// Directed bench for the write-back collector; inputs change and outputs are
// sampled on the falling clock edge.
module tb_airi5c_wb_collect;
  import airi5c_wb_collect_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        ex_valid_i;
  logic        ex_ready_o;
  logic [1:0]  wb_src_sel_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i;
  logic [31:0] alu_result_i;
  logic [31:0] csr_rdata_i;
  logic [31:0] pc_i;
  logic        was_compressed_i;
  logic [2:0]  mem_type_i;
  logic [1:0]  mem_addr_lsb_i;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        dmem_err_i;
  logic        rf_wen_o;
  logic [4:0]  rf_waddr_o;
  logic [31:0] rf_wdata_o;
  logic        load_err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  airi5c_wb_collect dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .ex_valid_i       (ex_valid_i),
    .ex_ready_o       (ex_ready_o),
    .wb_src_sel_i     (wb_src_sel_i),
    .rd_addr_i        (rd_addr_i),
    .rd_wen_i         (rd_wen_i),
    .alu_result_i     (alu_result_i),
    .csr_rdata_i      (csr_rdata_i),
    .pc_i             (pc_i),
    .was_compressed_i (was_compressed_i),
    .mem_type_i       (mem_type_i),
    .mem_addr_lsb_i   (mem_addr_lsb_i),
    .dmem_rvalid_i    (dmem_rvalid_i),
    .dmem_rdata_i     (dmem_rdata_i),
    .dmem_err_i       (dmem_err_i),
    .rf_wen_o         (rf_wen_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .load_err_o       (load_err_o)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one instruction for a single accept edge, return at the next negedge
  task automatic applyStimulus(input logic [1:0] sel, input logic [4:0] rd,
                               input logic wen, input logic [31:0] alu,
                               input logic [31:0] csr, input logic [31:0] pc,
                               input logic comp, input logic [2:0] mtype,
                               input logic [1:0] lsb);
    wb_src_sel_i     = sel;
    rd_addr_i        = rd;
    rd_wen_i         = wen;
    alu_result_i     = alu;
    csr_rdata_i      = csr;
    pc_i             = pc;
    was_compressed_i = comp;
    mem_type_i       = mtype;
    mem_addr_lsb_i   = lsb;
    ex_valid_i       = 1'b1;
    @(negedge clk_i);
    ex_valid_i       = 1'b0;
    alu_result_i     = 32'hA5A5_A5A5;
    csr_rdata_i      = 32'h5A5A_5A5A;
    mem_type_i       = 3'b111;
    mem_addr_lsb_i   = 2'd0;
  endtask

  // Accept a load, idle for gap cycles with ready checked low, then respond
  task automatic loadStep(input string tag, input logic [2:0] mtype,
                          input logic [1:0] lsb, input logic [4:0] rd,
                          input logic [31:0] rdata, input logic err,
                          input int gap);
    applyStimulus(WB_SRC_MEM, rd, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, mtype, lsb);
    for (int i = 0; i < gap; i++) begin
      checkOutput({tag, "_ready_wait"}, 32'(ex_ready_o), 32'd0);
      @(negedge clk_i);
    end
    checkOutput({tag, "_ready_resp"}, 32'(ex_ready_o), 32'd0);
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i  = rdata;
    dmem_err_i    = err;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    dmem_err_i    = 1'b0;
    dmem_rdata_i  = 32'hDEAD_0000;
  endtask

  // Linear directed sequence
  initial begin
    rst_i = 1'b1;
    ex_valid_i = 1'b0; wb_src_sel_i = '0; rd_addr_i = '0; rd_wen_i = 1'b0;
    alu_result_i = '0; csr_rdata_i = '0; pc_i = '0; was_compressed_i = 1'b0;
    mem_type_i = '0; mem_addr_lsb_i = '0;
    dmem_rvalid_i = 1'b0; dmem_rdata_i = '0; dmem_err_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checkOutput("rst_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("rst_wen",   32'(rf_wen_o),   32'd0);
    checkOutput("rst_waddr", 32'(rf_waddr_o), 32'd0);
    checkOutput("rst_wdata", rf_wdata_o,      32'd0);
    checkOutput("rst_err",   32'(load_err_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // ALU result, one-cycle pulse
    applyStimulus(WB_SRC_ALU, 5'd5, 1'b1, 32'h1234_5678, 32'h0, 32'h0, 1'b0, 3'd0, 2'd0);
    checkOutput("alu_wen",   32'(rf_wen_o),   32'd1);
    checkOutput("alu_waddr", 32'(rf_waddr_o), 32'd5);
    checkOutput("alu_wdata", rf_wdata_o,      32'h1234_5678);
    @(negedge clk_i);
    checkOutput("alu_pulse_end", 32'(rf_wen_o), 32'd0);
    checkOutput("alu_hold_addr", 32'(rf_waddr_o), 32'd5);

    // CSR then LINK back-to-back
    applyStimulus(WB_SRC_CSR, 5'd9, 1'b1, 32'h1111_1111, 32'hDEAD_BEEF, 32'h0, 1'b0, 3'd0, 2'd0);
    checkOutput("csr_wen",   32'(rf_wen_o),   32'd1);
    checkOutput("csr_waddr", 32'(rf_waddr_o), 32'd9);
    checkOutput("csr_wdata", rf_wdata_o,      32'hDEAD_BEEF);
    applyStimulus(WB_SRC_LINK, 5'd10, 1'b1, 32'h2222_2222, 32'h3333_3333, 32'h0000_0100, 1'b1, 3'd0, 2'd0);
    checkOutput("link_c_wen",   32'(rf_wen_o),   32'd1);
    checkOutput("link_c_waddr", 32'(rf_waddr_o), 32'd10);
    checkOutput("link_c_wdata", rf_wdata_o,      32'h0000_0102);
    applyStimulus(WB_SRC_LINK, 5'd11, 1'b1, 32'h0, 32'h0, 32'hFFFF_FFFC, 1'b0, 3'd0, 2'd0);
    checkOutput("link_wrap_wdata", rf_wdata_o, 32'h0000_0000);
    applyStimulus(WB_SRC_LINK, 5'd10, 1'b1, 32'h0, 32'h0, 32'h0000_0100, 1'b0, 3'd0, 2'd0);
    checkOutput("link_u_wdata", rf_wdata_o, 32'h0000_0104);
    @(negedge clk_i);

    // No write when rd_wen is low; port holds previous values
    applyStimulus(WB_SRC_ALU, 5'd12, 1'b0, 32'h0000_0055, 32'h0, 32'h0, 1'b0, 3'd0, 2'd0);
    checkOutput("nowen_wen",   32'(rf_wen_o),   32'd0);
    checkOutput("nowen_waddr", 32'(rf_waddr_o), 32'd10);
    checkOutput("nowen_wdata", rf_wdata_o,      32'h0000_0104);

    // LB byte 3 with a three-cycle response
    loadStep("lb3", RV32_FUNCT3_LB, 2'd3, 5'd6, 32'h80AA_BBCC, 1'b0, 2);
    checkOutput("lb3_wen",   32'(rf_wen_o),   32'd1);
    checkOutput("lb3_waddr", 32'(rf_waddr_o), 32'd6);
    checkOutput("lb3_wdata", rf_wdata_o,      32'hFFFF_FF80);
    checkOutput("lb3_ready", 32'(ex_ready_o), 32'd1);
    loadStep("lbu3", RV32_FUNCT3_LBU, 2'd3, 5'd7, 32'h80AA_BBCC, 1'b0, 2);
    checkOutput("lbu3_wdata", rf_wdata_o, 32'h0000_0080);
    loadStep("lhu2", RV32_FUNCT3_LHU, 2'd2, 5'd7, 32'h80AA_BBCC, 1'b0, 0);
    checkOutput("lhu2_wdata", rf_wdata_o, 32'h0000_80AA);
    loadStep("lh0", RV32_FUNCT3_LH, 2'd0, 5'd8, 32'h80AA_BBCC, 1'b0, 1);
    checkOutput("lh0_wdata", rf_wdata_o, 32'hFFFF_BBCC);
    loadStep("lh3", RV32_FUNCT3_LH, 2'd3, 5'd8, 32'h80AA_BBCC, 1'b0, 0);
    checkOutput("lh3_wdata", rf_wdata_o, 32'hFFFF_80AA);
    loadStep("lb1", RV32_FUNCT3_LB, 2'd1, 5'd8, 32'h80AA_BBCC, 1'b0, 0);
    checkOutput("lb1_wdata", rf_wdata_o, 32'hFFFF_FFBB);
    loadStep("lbu2", RV32_FUNCT3_LBU, 2'd2, 5'd8, 32'h80AA_BBCC, 1'b0, 0);
    checkOutput("lbu2_wdata", rf_wdata_o, 32'h0000_00AA);
    loadStep("lw", RV32_FUNCT3_LW, 2'd1, 5'd9, 32'h80AA_BBCC, 1'b0, 0);
    checkOutput("lw_wdata", rf_wdata_o, 32'h80AA_BBCC);
    loadStep("lundef", 3'b011, 2'd2, 5'd9, 32'h1357_9BDF, 1'b0, 0);
    checkOutput("lundef_wdata", rf_wdata_o, 32'h1357_9BDF);

    // Load to x0: waits for the response, writes nothing
    loadStep("lx0", RV32_FUNCT3_LW, 2'd0, 5'd0, 32'h7777_7777, 1'b0, 0);
    checkOutput("lx0_wen",   32'(rf_wen_o),   32'd0);
    checkOutput("lx0_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("lx0_wdata", rf_wdata_o,      32'h1357_9BDF);

    // Erroneous response: error pulse, no write
    loadStep("lerr", RV32_FUNCT3_LW, 2'd0, 5'd14, 32'h6666_6666, 1'b1, 1);
    checkOutput("lerr_err",   32'(load_err_o), 32'd1);
    checkOutput("lerr_wen",   32'(rf_wen_o),   32'd0);
    checkOutput("lerr_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("lerr_waddr", 32'(rf_waddr_o), 32'd9);
    @(negedge clk_i);
    checkOutput("lerr_pulse_end", 32'(load_err_o), 32'd0);

    // Stray response in IDLE is ignored
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h4444_4444; dmem_err_i = 1'b1;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0; dmem_err_i = 1'b0;
    checkOutput("stray_wen", 32'(rf_wen_o),   32'd0);
    checkOutput("stray_err", 32'(load_err_o), 32'd0);

    // Asynchronous reset while waiting for a load
    applyStimulus(WB_SRC_MEM, 5'd15, 1'b1, 32'h0, 32'h0, 32'h0, 1'b0, RV32_FUNCT3_LW, 2'd0);
    checkOutput("arst_pre_ready", 32'(ex_ready_o), 32'd0);
    #2 rst_i = 1'b1;
    #1;
    checkOutput("arst_ready", 32'(ex_ready_o), 32'd1);
    checkOutput("arst_wen",   32'(rf_wen_o),   32'd0);
    checkOutput("arst_waddr", 32'(rf_waddr_o), 32'd0);
    checkOutput("arst_wdata", rf_wdata_o,      32'd0);
    checkOutput("arst_err",   32'(load_err_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    dmem_rvalid_i = 1'b0;
    checkOutput("late_wen",   32'(rf_wen_o),   32'd0);
    checkOutput("late_wdata", rf_wdata_o,      32'd0);
    checkOutput("late_ready", 32'(ex_ready_o), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/airi5c_wb_collect.md
# airi5c_wb_collect

Write-back collector at the end of the execute path: counterpart to the ALU operand-source selection. It accepts one retiring instruction per handshake from EX, selects the result source (ALU, load data, CSR, or link address), and waits for the data-memory response on loads. It aligns and sign-/zero-extends load data and drives a single registered register-file write port, which also serves as the bypass source for the operand muxes.

## Interface
Parameters: none. Widths come from `XPR_LEN` and `WB_SRC_SEL_WIDTH` in the shared constants headers.
- clk_i  in  1  core clock; single clock domain
- rst_i  in  1  reset, asynchronous, active-high
- ex_valid_i  in  1  EX presents a retiring instruction
- ex_ready_o  out  1  collector can accept; high only in IDLE
- wb_src_sel_i  in  `WB_SRC_SEL_WIDTH`  result source: `WB_SRC_ALU`, `WB_SRC_MEM`, `WB_SRC_CSR`, `WB_SRC_LINK`
- rd_addr_i  in  5  destination register
- rd_wen_i  in  1  instruction writes rd
- alu_result_i  in  `XPR_LEN`  ALU result
- csr_rdata_i  in  `XPR_LEN`  CSR read data
- pc_i  in  `XPR_LEN`  PC of the instruction
- was_compressed_i  in  1  instruction was 16-bit
- mem_type_i  in  3  load funct3: LB=000, LH=001, LW=010, LBU=100, LHU=101
- mem_addr_lsb_i  in  2  byte address bits [1:0] of the load
- dmem_rvalid_i  in  1  load response valid
- dmem_rdata_i  in  `XPR_LEN`  raw load word
- dmem_err_i  in  1  bus error; qualified by dmem_rvalid_i
- rf_wen_o  out  1  register-file write strobe; one-cycle pulse
- rf_waddr_o  out  5  write address
- rf_wdata_o  out  `XPR_LEN`  write data
- load_err_o  out  1  one-cycle pulse on an erroneous load response

## Operation
- FSM states are IDLE and WAIT_MEM. Reset state is IDLE.
- Accept occurs when ex_valid_i & ex_ready_o. Inputs are sampled on that edge, and rd_addr_i, rd_wen_i, mem_type_i and mem_addr_lsb_i are captured.
- Non-MEM source, IDLE→IDLE:
  - The result is registered on the accept edge.
  - ALU source gives alu_result_i.
  - CSR source gives csr_rdata_i.
  - LINK source gives pc_i + (was_compressed_i ? 2 : 4), modulo 2^`XPR_LEN`.
  - An undefined select gives data 0. The write strobe is still governed by rd_wen_i.
- MEM source: IDLE→WAIT_MEM. Stay in WAIT_MEM until dmem_rvalid_i, then return to IDLE.
- Load alignment:
  - LB/LBU take byte lsb.
  - LH/LHU take the halfword at lsb[1]; lsb[0] is ignored.
  - LW takes the full word; lsb is ignored.
  - Misalignment is trapped upstream.
  - LB/LH sign-extend; LBU/LHU zero-extend. Any undefined mem_type is treated as LW.
- Write strobe: rf_wen_o = rd_wen_i & (rd_addr_i != 0) & !error. A load to x0 still waits for its response.
- Error: a response with dmem_err_i produces no write and pulses load_err_o. FSM returns to IDLE.
- dmem_rvalid_i in IDLE is ignored; no write and no error.

## Timing
- Reset values: ex_ready_o=1, rf_wen_o=0, rf_waddr_o=0, rf_wdata_o=0, load_err_o=0, state IDLE.
- Reset during WAIT_MEM aborts the load. Any later stray response is ignored (IDLE rule).
- ex_ready_o is a pure function of state (IDLE). It has no combinational path from ex_valid_i or dmem_rvalid_i.
- Non-load latency is 1: accept at edge t gives rf_wen_o high in the cycle after t. Back-to-back accepts give back-to-back pulses.
- Load latency is response + 1:
  - Accept at edge t; ex_ready_o is low from t.
  - rvalid seen in cycle c.
  - At edge c+1: rf_wen_o/rf_wdata_o are valid, load_err_o pulses on error, and ex_ready_o returns high.
- A response can arrive in the cycle immediately after accept (c = t+1).
- rf_waddr_o and rf_wdata_o hold their last values while rf_wen_o=0.

## Structure
- Add `WB_SRC_SEL_WIDTH` and the `WB_SRC_*` codes to airi5c_ctrl_constants.vh.
- Add the load funct3 codes to rv32_opcodes.vh.
- Put the state encoding in localparams in the module.
- Sub-module airi5c_load_align is combinational: inputs mem_type, addr_lsb, rdata; output the extended word. It is reusable by the debug module.

## Test plan
- Accept ALU source, rd=5, alu_result=0x1234_5678 → next cycle rf_wen_o=1, waddr=5, wdata=0x1234_5678; pulse is one cycle.
- LINK source, pc=0x0000_0100: was_compressed=1 → wdata=0x0000_0102. With was_compressed=0 → 0x0000_0104. With pc=0xFFFF_FFFC, uncompressed → 0x0000_0000.
- LB, lsb=3, rdata=0x80AA_BBCC, rvalid 3 cycles after accept:
  - ex_ready_o is low for those cycles.
  - wdata=0xFFFF_FF80.
  - Repeat as LBU → 0x0000_0080. LHU, lsb=2 → 0x0000_80AA.
- Load with rd=0, response next cycle → no rf_wen_o; ex_ready_o high again after the response edge. Load with dmem_err_i=1 → load_err_o single pulse, rf_wen_o stays 0.
- Assert rst_i asynchronously in WAIT_MEM → outputs at reset values immediately. A later dmem_rvalid_i produces no write.
